// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared constants for the CPU datapath register file.
//   DW_DEF   : default data width
//   AW_DEF   : default register address width
//   REG_ZERO : architectural index of the hard-wired zero register
package cpu_pkg;
    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int REG_ZERO = 0;
endpackage : cpu_pkg

// File: rtl/regfile_mp_fwd.sv
// regfile_mp_fwd
// Combinational write-to-read forwarding match for one read port.
// It scans all write ports and picks the highest-index enabled port whose
// address matches the read address.
// Ports:
//   i_raddr   : read address of this port
//   i_we      : write enables, one per write port
//   i_waddr   : packed write addresses, port j at [j*AW +: AW]
//   i_wdata   : packed write data, port j at [j*DW +: DW]
//   i_rf_busy : stored busy bit of the addressed register
//   o_hit     : a same-cycle write is forwarded to this port
//   o_data    : forwarded write data (valid when o_hit)
//   o_busy    : busy bit, masked when the value arrives through the bypass
module regfile_mp_fwd
    import cpu_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int NW       = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0]    i_raddr,
    input  logic [NW-1:0]    i_we,
    input  logic [NW*AW-1:0] i_waddr,
    input  logic [NW*DW-1:0] i_wdata,
    input  logic             i_rf_busy,
    output logic             o_hit,
    output logic [DW-1:0]    o_data,
    output logic             o_busy
);

    logic          w_is_zero;
    logic          w_hit;
    logic [DW-1:0] w_data;

    // Register 0 is never forwarded: a write to it is discarded, so a read
    // must keep returning the stored zero.
    assign w_is_zero = (ZERO_REG != 0) && (i_raddr == AW'(REG_ZERO));

    // NOTE: every variable assigned in this block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_hit  = 1'b0;
        w_data = '0;
        // Ascending scan: a later (higher-index) match overrides earlier ones.
        for (int j = 0; j < NW; j++) begin
            if ((BYPASS != 0) && i_we[j] && (i_waddr[j*AW +: AW] == i_raddr)) begin
                w_hit  = 1'b1;
                w_data = i_wdata[j*DW +: DW];
            end
        end
    end

    assign o_hit  = w_hit && !w_is_zero;
    assign o_data = w_data;
    assign o_busy = i_rf_busy && !o_hit;

endmodule : regfile_mp_fwd

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port general-purpose register file with optional write-to-read
// bypass and a per-register busy scoreboard for RAW hazard detection.
// Ports:
//   clk       : clock, all state updates on the rising edge
//   reset     : synchronous active-high reset (registers, busy, count -> 0)
//   raddr     : NR packed read addresses, port i at [i*AW +: AW]
//   rdata     : NR packed combinational read data, port i at [i*DW +: DW]
//   rbusy     : per read port, addressed register has a pending producer
//   we        : NW write enables
//   waddr     : NW packed write addresses
//   wdata     : NW packed write data
//   iss_valid : issue event, marks iss_addr busy
//   iss_addr  : destination register of the issued instruction
//   busy_cnt  : number of registers currently busy
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int NR       = 2,
    parameter int NW       = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    output logic [NR-1:0]    rbusy,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW*DW-1:0] wdata,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_addr,
    output logic [AW:0]      busy_cnt
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    r_rf [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [AW:0]      r_busy_cnt;

    logic [NW-1:0]    w_wr_ok;
    logic             w_iss_ok;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [AW:0]      w_inc;
    logic [AW:0]      w_dec;

    // Writes and issues aimed at the zero register are dropped here, so r_rf[0]
    // and r_busy[0] stay zero forever and reads need no extra masking.
    always_comb begin
        for (int j = 0; j < NW; j++) begin
            w_wr_ok[j] = we[j] &&
                !((ZERO_REG != 0) && (waddr[j*AW +: AW] == AW'(REG_ZERO)));
        end
        w_iss_ok = iss_valid &&
            !((ZERO_REG != 0) && (iss_addr == AW'(REG_ZERO)));
    end

    // Next busy vector: writebacks clear, then issue sets, so a same-cycle
    // set on the same register wins. The counter follows the net change.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int j = 0; j < NW; j++) begin
            if (w_wr_ok[j]) w_busy_nxt[waddr[j*AW +: AW]] = 1'b0;
        end
        if (w_iss_ok) w_busy_nxt[iss_addr] = 1'b1;

        w_inc = '0;
        w_dec = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_inc = w_inc + (AW+1)'(!r_busy[k] &&  w_busy_nxt[k]);
            w_dec = w_dec + (AW+1)'( r_busy[k] && !w_busy_nxt[k]);
        end
    end

    // NOTE: the register array is reset entry by entry because the design
    // guarantees zero contents after reset; this makes it flops, not RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) r_rf[k] <= '0;
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            // NOTE: non-blocking updates; with several ports on one address
            // the last scheduled (highest-index) assignment takes effect.
            for (int j = 0; j < NW; j++) begin
                if (w_wr_ok[j]) r_rf[waddr[j*AW +: AW]] <= wdata[j*DW +: DW];
            end
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= r_busy_cnt + w_inc - w_dec;
        end
    end

    assign busy_cnt = r_busy_cnt;

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_hit;
        logic [DW-1:0] w_fwd;

        assign w_ra = raddr[i*AW +: AW];

        regfile_mp_fwd #(
            .DW       (DW),
            .AW       (AW),
            .NW       (NW),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_fwd (
            .i_raddr   (w_ra),
            .i_we      (we),
            .i_waddr   (waddr),
            .i_wdata   (wdata),
            .i_rf_busy (r_busy[w_ra]),
            .o_hit     (w_hit),
            .o_data    (w_fwd),
            .o_busy    (rbusy[i])
        );

        assign rdata[i*DW +: DW] = w_hit ? w_fwd : r_rf[w_ra];
    end

endmodule : regfile_mp

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file; successor to the single-write, dual-read regfile in the CPU datapath.
- Adds the following:
  - configurable width, depth, read-port count and write-port count;
  - synchronous reset-to-zero;
  - optional write-to-read bypass;
  - a per-register busy scoreboard, so decode can detect RAW hazards against in-flight producers.
- Sits between decode (reads, busy-set at issue) and writeback (writes, busy-clear).

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW registers.
- NR, 2, number of read ports.
- NW, 2, number of write ports.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = reads return the stored value only.
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never marked busy.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- raddr  input  NR*AW  read addresses; port i uses bits [i*AW +: AW].
- rdata  output  NR*DW  read data, combinational; port i uses bits [i*DW +: DW].
- rbusy  output  NR  per read port: the addressed register has a pending producer.
- we  input  NW  write enables, one per write port.
- waddr  input  NW*AW  write addresses.
- wdata  input  NW*DW  write data.
- iss_valid  input  1  issue event: mark iss_addr busy.
- iss_addr  input  AW  destination register of the issued instruction.
- busy_cnt  output  AW+1  number of registers currently busy.

Behaviour:
- Reset:
  - While reset=1 at a clk edge: all 2**AW registers <= 0, all busy bits <= 0, busy_cnt <= 0.
  - Takes effect in one cycle.
  - Writes and issues presented in the reset cycle are discarded.
  - Reset mid-operation discards all pending busy state.
- Write:
  - At posedge, for each port j with we[j]=1, rf[waddr_j] <= wdata_j and busy[waddr_j] <= 0.
  - If several ports target the same address, the highest-index port wins.
  - Ports with we=0 have no effect.
- Read:
  - Combinational.
  - With BYPASS=1: if any enabled write port matches raddr_i, rdata_i = wdata of the highest-index matching port; otherwise rdata_i = rf[raddr_i].
  - With BYPASS=0: rdata_i = rf[raddr_i] always; the new value becomes visible the cycle after the write.
- Zero register (ZERO_REG=1):
  - Any read of address 0 returns 0 and rbusy=0, regardless of bypass.
  - Writes and issues to address 0 are ignored.
- Scoreboard:
  - At posedge, iss_valid=1 sets busy[iss_addr] <= 1.
  - Simultaneous set and clear of the same register: the set wins (the new producer supersedes the one writing back).
- rbusy_i:
  - rbusy_i = busy[raddr_i], except it reads 0 when BYPASS=1 and an enabled write port matches raddr_i in the same cycle (the value is available through the bypass).
  - A same-cycle issue to raddr_i does not raise rbusy_i until the next cycle.
- busy_cnt:
  - Registered.
  - Always equals the popcount of the busy vector after each edge.
  - Maintained incrementally (+1 per 0->1 transition, -1 per 1->0 transition, net per cycle); never wraps, since the maximum is 2**AW.
- No internal FSM beyond the busy vector and the counter.
- Fully synthesisable: no initial blocks; reset is the sole initialisation.

Decomposition:
- Shared package (cpu_pkg) holds:
  - default constants DW_DEF=32, AW_DEF=5;
  - a localparam REG_ZERO = 0.
- One sub-module is natural: regfile_mp_fwd, the combinational per-read-port priority match over the NW write ports. It returns hit, data and the masked busy value, and is instantiated NR times in a generate loop.
- Storage, the scoreboard and the counter stay in the top module.

Test Plan:
- Reset then read: assert reset for one cycle, read r1..r31 -> all rdata=0, rbusy=0, busy_cnt=0.
- Basic write/read (BYPASS=0):
  - we[0]=1, waddr=3, wdata=0xDEADBEEF; the same-cycle read of r3 returns 0.
  - The next cycle returns 0xDEADBEEF.
- Bypass and write priority (BYPASS=1):
  - Ports 0 and 1 both write r7, with 0x11111111 and 0x22222222.
  - Same-cycle rdata for r7 = 0x22222222; the stored value the next cycle = 0x22222222.
- Zero register:
  - Write 0x55 to r0 with iss_valid, iss_addr=0 -> r0 reads 0, rbusy=0, busy_cnt unchanged.
- Scoreboard:
  - Issue r5, then issue r6 -> busy_cnt=2 and rbusy=1 on reads of r5.
  - Write r5 -> rbusy=0 in the same cycle (bypass); busy_cnt=1 the next cycle.
- Simultaneous events:
  - Issue r9 and write r9 in the same cycle -> busy[r9]=1 afterwards and stored data updated.
  - Then reset -> busy_cnt=0 and r9=0.
